// File: rtl/fir_out_requantizer.sv
// FIR output requantizer: round/shift, saturate to 16-bit signed, buffer in a FIFO, count saturations and drops.
// Optional rounding selected by macro FIR_REQ_ROUND_EN (undefined: truncate toward -inf).
module fir_out_requantizer #(
  parameter int unsigned SHIFT = 15,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   yn,
  input  logic          yn_valid,
  output logic [15:0]   out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW:0]   fifo_level,
  output logic [15:0]   sat_cnt,
  output logic [15:0]   drop_cnt,
  output logic          sat_flag
);

  localparam int unsigned IW = 32;
  localparam int unsigned OW = 16;
  localparam int unsigned TW = IW + 1;
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = 16;

`ifdef FIR_REQ_ROUND_EN
  localparam logic [TW-1:0] RND = TW'(1) << (SHIFT - 1);
`else
  localparam logic [TW-1:0] RND = '0;
`endif
  localparam logic signed [TW-1:0] SAT_MAX = TW'(32767);
  localparam logic signed [TW-1:0] SAT_MIN = -TW'(32768);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  logic [OW-1:0]  stage_q, stage_d;
  logic           stage_valid_q, stage_valid_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]  level_q, level_d;
  logic [CW-1:0]  sat_cnt_q, sat_cnt_d;
  logic [CW-1:0]  drop_cnt_q, drop_cnt_d;
  logic           sat_flag_q, sat_flag_d;
  logic [OW-1:0]  mem_q [DEPTH];

  logic signed [TW-1:0] t_c;
  logic signed [TW-1:0] q_c;
  logic [OW-1:0]        sq_c;
  logic                 sat_c;
  logic                 pop_c;
  logic                 push_c;
  logic                 drop_c;

  // 33-bit add cannot wrap; arithmetic shift then clamp to 16-bit signed range
  always_comb begin
    t_c   = $signed({yn[IW-1], yn} + RND);
    q_c   = t_c >>> SHIFT;
    sat_c = 1'b0;
    sq_c  = q_c[OW-1:0];
    if (q_c > SAT_MAX) begin
      sq_c  = 16'h7FFF;
      sat_c = 1'b1;
    end else if (q_c < SAT_MIN) begin
      sq_c  = 16'h8000;
      sat_c = 1'b1;
    end
  end

  // A full FIFO still accepts a push when the head is popped in the same cycle
  always_comb begin
    pop_c  = (level_q != '0) && out_ready;
    push_c = stage_valid_q && ((level_q != FULL_LVL) || pop_c);
    drop_c = stage_valid_q && !push_c;

    stage_d       = stage_q;
    stage_valid_d = yn_valid;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    level_d       = level_q;
    sat_cnt_d     = sat_cnt_q;
    drop_cnt_d    = drop_cnt_q;
    sat_flag_d    = sat_flag_q;

    if (yn_valid) begin
      stage_d = sq_c;
      if (sat_c) begin
        sat_flag_d = 1'b1;
        if (sat_cnt_q != CNT_MAX) sat_cnt_d = sat_cnt_q + CW'(1);
      end
    end
    if (push_c) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_c && !pop_c)      level_d = level_q + LW'(1);
    else if (pop_c && !push_c) level_d = level_q - LW'(1);
    if (drop_c && (drop_cnt_q != CNT_MAX)) drop_cnt_d = drop_cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q       <= '0;
      stage_valid_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      sat_cnt_q     <= '0;
      drop_cnt_q    <= '0;
      sat_flag_q    <= 1'b0;
    end else begin
      stage_q       <= stage_d;
      stage_valid_q <= stage_valid_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      sat_cnt_q     <= sat_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
      sat_flag_q    <= sat_flag_d;
    end
  end

  // Storage needs no reset; the level gates visibility of its contents
  always_ff @(posedge clk) begin
    if (!rst && push_c) mem_q[wr_ptr_q] <= stage_q;
  end

  assign out_valid  = (level_q != '0);
  assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_level = level_q;
  assign sat_cnt    = sat_cnt_q;
  assign drop_cnt   = drop_cnt_q;
  assign sat_flag   = sat_flag_q;

endmodule
